cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, byte address width (tag = ADDR_W-3 bits, index = 3 bits).
REQ-002 SHALL have parameter DATA_W, default 8, line/word data width.
REQ-003 SHALL have port clock, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port miss_req, input, 1, cache reports a miss needing service.
REQ-006 SHALL have port req_addr, input, ADDR_W, missed address {tag,index}.
REQ-007 SHALL have port req_wren, input, 1, missed access was a write.
REQ-008 SHALL have port req_wdata, input, DATA_W, write data of a write miss.
REQ-009 SHALL have port victim_dirty, input, 1, LRU victim way is valid and dirty.
REQ-010 SHALL have port victim_tag, input, ADDR_W-3, victim way tag.
REQ-011 SHALL have port victim_data, input, DATA_W, victim way data.
REQ-012 SHALL have port busy, output, 1, miss in service.
REQ-013 SHALL have port fill_valid, output, 1, one-cycle strobe: write fill into victim way.
REQ-014 SHALL have port fill_data, output, DATA_W, line to install.
REQ-015 SHALL have port fill_dirty, output, 1, installed line is dirty.
REQ-016 SHALL have ports mem_req (out,1), mem_we (out,1), mem_addr (out,ADDR_W), mem_wdata (out,DATA_W), mem_ack (in,1), mem_rdata (in,DATA_W): main-memory request/acknowledge port.

Function
REQ-017 SHALL implement FSM states IDLE, WRITEBACK, FETCH, FILL.
REQ-018 IDLE: miss_req=1 SHALL register req_addr, req_wren, req_wdata, victim_tag, victim_data, victim_dirty; next state WRITEBACK if victim_dirty, else FETCH.
REQ-019 WRITEBACK SHALL drive mem_req=1, mem_we=1, mem_addr={victim_tag, req_addr[2:0]}, mem_wdata=victim_data, held stable until mem_ack=1, then next state FETCH.
REQ-020 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=registered req_addr until mem_ack=1, capturing mem_rdata that same edge; next state FILL.
REQ-021 FILL SHALL assert fill_valid for exactly one cycle, then return to IDLE.
REQ-022 fill_data SHALL equal registered req_wdata with fill_dirty=1 on a write miss, else captured mem_rdata with fill_dirty=0.
REQ-023 busy SHALL be 1 in every state except IDLE; miss_req while busy SHALL be ignored.
REQ-024 mem_ack SHALL be sampled only in WRITEBACK/FETCH; an ack on the first cycle of a state SHALL be accepted (minimum service: 2 cycles clean, 3 cycles dirty, IDLE excluded).
REQ-025 mem_req SHALL be 0 in IDLE and FILL; mem_we/mem_addr/mem_wdata are don't-care when mem_req=0 but SHALL be registered outputs.
REQ-026 miss_req in the FILL cycle SHALL be ignored; it is accepted on the following IDLE cycle.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, busy=0, fill_valid=0, fill_dirty=0, fill_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, aborting any in-flight transfer.
REQ-028 After resetn deasserts, the first miss_req SHALL be accepted on the first rising edge.

Configuration
REQ-029 With CACHE_STATS_EN defined, SHALL add outputs miss_count[7:0] and wb_count[7:0], incremented on entry to FETCH resp. WRITEBACK, saturating at 255, cleared by reset.
REQ-030 Without CACHE_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Clean read miss: addr=5'b10011, victim_dirty=0, mem_ack one cycle after mem_req, mem_rdata=8'hA5 -> no write cycle, mem_addr=5'b10011, fill_valid 1 cycle, fill_data=8'hA5, fill_dirty=0.
REQ-032 Dirty eviction: victim_tag=2'b01, victim_data=8'h3C, addr=5'b11010 -> mem write addr=5'b01010 data=8'h3C, then read addr=5'b11010, then fill.
REQ-033 Write miss: req_wren=1, req_wdata=8'h7E, clean victim -> fetch issued, fill_data=8'h7E, fill_dirty=1.
REQ-034 mem_ack held low 10 cycles in WRITEBACK -> mem_req/mem_addr/mem_wdata stable, busy=1 throughout; miss_req pulses meanwhile ignored.
REQ-035 resetn low mid-FETCH -> mem_req=0 and busy=0 asynchronously, no fill_valid; next miss served normally.
REQ-036 CACHE_STATS_EN: 300 dirty misses -> miss_count=255, wb_count=255.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss-service controller for a small set-associative cache: optional dirty-victim writeback, line fetch, then a single-cycle fill strobe.
// Optional build macro CACHE_STATS_EN adds saturating miss/writeback counters.
module cache_refill_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_wren,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              victim_dirty,
   input  logic [ADDR_W-4:0] victim_tag,
   input  logic [DATA_W-1:0] victim_data,
   output logic              busy,
   output logic              fill_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_dirty,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [7:0]        miss_count,
   output logic [7:0]        wb_count
`endif
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              wren_reg, wren_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic              fill_valid_reg, fill_valid_next;
   logic [DATA_W-1:0] fill_data_reg, fill_data_next;
   logic              fill_dirty_reg, fill_dirty_next;
   logic              mem_req_reg, mem_req_next;
   logic              mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

   // The writeback address/data are loaded straight into the memory-port
   // registers on the accept edge, so the victim needs no separate copy.
   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      wren_next       = wren_reg;
      wdata_next      = wdata_reg;
      fill_valid_next = 1'b0;
      fill_data_next  = fill_data_reg;
      fill_dirty_next = fill_dirty_reg;
      mem_req_next    = mem_req_reg;
      mem_we_next     = mem_we_reg;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      case (state_reg)
         IDLE: begin
            if (miss_req) begin
               addr_next    = req_addr;
               wren_next    = req_wren;
               wdata_next   = req_wdata;
               mem_req_next = 1'b1;
               if (victim_dirty) begin
                  state_next     = WRITEBACK;
                  mem_we_next    = 1'b1;
                  mem_addr_next  = {victim_tag, req_addr[2:0]};
                  mem_wdata_next = victim_data;
               end else begin
                  state_next    = FETCH;
                  mem_we_next   = 1'b0;
                  mem_addr_next = req_addr;
               end
            end
         end
         WRITEBACK: begin
            if (mem_ack) begin
               state_next    = FETCH;
               mem_req_next  = 1'b1;
               mem_we_next   = 1'b0;
               mem_addr_next = addr_reg;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               // A write miss installs its own data; the fetched word is dropped.
               state_next      = FILL;
               mem_req_next    = 1'b0;
               fill_valid_next = 1'b1;
               fill_data_next  = wren_reg ? wdata_reg : mem_rdata;
               fill_dirty_next = wren_reg;
            end
         end
         FILL: begin
            state_next = IDLE;
         end
         default: begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         wren_reg       <= 1'b0;
         wdata_reg      <= '0;
         fill_valid_reg <= 1'b0;
         fill_data_reg  <= '0;
         fill_dirty_reg <= 1'b0;
         mem_req_reg    <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         wren_reg       <= wren_next;
         wdata_reg      <= wdata_next;
         fill_valid_reg <= fill_valid_next;
         fill_data_reg  <= fill_data_next;
         fill_dirty_reg <= fill_dirty_next;
         mem_req_reg    <= mem_req_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
      end
   end

   assign busy       = (state_reg != IDLE);
   assign fill_valid = fill_valid_reg;
   assign fill_data  = fill_data_reg;
   assign fill_dirty = fill_dirty_reg;
   assign mem_req    = mem_req_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;

`ifdef CACHE_STATS_EN
   logic [7:0] miss_count_reg;
   logic [7:0] wb_count_reg;
   logic       enter_fetch;
   logic       enter_wb;

   assign enter_fetch = (state_next == FETCH) && (state_reg != FETCH);
   assign enter_wb    = (state_next == WRITEBACK) && (state_reg != WRITEBACK);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         miss_count_reg <= 8'd0;
         wb_count_reg   <= 8'd0;
      end else begin
         if (enter_fetch && (miss_count_reg != 8'hFF))
            miss_count_reg <= miss_count_reg + 8'd1;
         if (enter_wb && (wb_count_reg != 8'hFF))
            wb_count_reg <= wb_count_reg + 8'd1;
      end
   end

   assign miss_count = miss_count_reg;
   assign wb_count   = wb_count_reg;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed and randomized misses acting as the main memory.
// Define CACHE_STATS_EN for both bench and RTL to exercise the counters.
module tb_cache_refill_ctrl;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       miss_req = 1'b0;
   logic [4:0] req_addr = '0;
   logic       req_wren = 1'b0;
   logic [7:0] req_wdata = '0;
   logic       victim_dirty = 1'b0;
   logic [1:0] victim_tag = '0;
   logic [7:0] victim_data = '0;
   logic       busy, fill_valid, fill_dirty, mem_req, mem_we;
   logic [7:0] fill_data, mem_wdata;
   logic [4:0] mem_addr;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [7:0] miss_count, wb_count;
`endif

   int checks = 0;
   int failures = 0;
   int txn_id = 0;

   cache_refill_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
      .clock(clock), .resetn(resetn),
      .miss_req(miss_req), .req_addr(req_addr), .req_wren(req_wren), .req_wdata(req_wdata),
      .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
      .busy(busy), .fill_valid(fill_valid), .fill_data(fill_data), .fill_dirty(fill_dirty),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
      , .miss_count(miss_count), .wb_count(wb_count)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive junk on the request side while a miss is in service.
   task automatic drive_noise();
      miss_req     = 1'($urandom);
      req_addr     = 5'($urandom);
      req_wren     = 1'($urandom);
      req_wdata    = 8'($urandom);
      victim_dirty = 1'($urandom);
      victim_tag   = 2'($urandom);
      victim_data  = 8'($urandom);
   endtask

   // One full miss, acting as memory; expectations come from the miss parameters alone.
   task automatic run_miss(input logic [4:0] a, input logic wr, input logic [7:0] wd,
                           input logic vd, input logic [1:0] vt, input logic [7:0] vdat,
                           input logic [7:0] rd, input int wbd, input int fd, input bit noise);
      logic [4:0] exp_wb_addr;
      logic [7:0] exp_fill;
      exp_wb_addr = {vt, a[2:0]};
      exp_fill    = wr ? wd : rd;
      txn_id++;
      miss_req = 1'b1; req_addr = a; req_wren = wr; req_wdata = wd;
      victim_dirty = vd; victim_tag = vt; victim_data = vdat;
      @(negedge clock);
      miss_req = 1'b0;
      if (vd) begin
         for (int k = 0; k <= wbd; k++) begin
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wb_req: req=%b we=%b required 1/1 (txn %0d cyc %0d)", mem_req, mem_we, txn_id, k); end
            checks++; if (mem_addr !== exp_wb_addr) begin failures++; $display("FAIL wb_addr: got %b required %b (txn %0d)", mem_addr, exp_wb_addr, txn_id); end
            checks++; if (mem_wdata !== vdat) begin failures++; $display("FAIL wb_data: got %h required %h (txn %0d)", mem_wdata, vdat, txn_id); end
            checks++; if (busy !== 1'b1 || fill_valid !== 1'b0) begin failures++; $display("FAIL wb_busy: busy=%b fill_valid=%b required 1/0 (txn %0d)", busy, fill_valid, txn_id); end
            mem_ack = (k == wbd);
            if (noise) drive_noise();
            @(negedge clock);
            mem_ack = 1'b0; miss_req = 1'b0;
         end
      end
      for (int k = 0; k <= fd; k++) begin
         checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_req: req=%b we=%b required 1/0 (txn %0d cyc %0d)", mem_req, mem_we, txn_id, k); end
         checks++; if (mem_addr !== a) begin failures++; $display("FAIL rd_addr: got %b required %b (txn %0d)", mem_addr, a, txn_id); end
         checks++; if (busy !== 1'b1 || fill_valid !== 1'b0) begin failures++; $display("FAIL rd_busy: busy=%b fill_valid=%b required 1/0 (txn %0d)", busy, fill_valid, txn_id); end
         mem_ack   = (k == fd);
         mem_rdata = (k == fd) ? rd : 8'($urandom);
         if (noise) drive_noise();
         @(negedge clock);
         mem_ack = 1'b0; miss_req = 1'b0;
      end
      checks++; if (fill_valid !== 1'b1) begin failures++; $display("FAIL fill_valid: got %b required 1 (txn %0d)", fill_valid, txn_id); end
      checks++; if (fill_data !== exp_fill) begin failures++; $display("FAIL fill_data: got %h required %h (txn %0d)", fill_data, exp_fill, txn_id); end
      checks++; if (fill_dirty !== wr) begin failures++; $display("FAIL fill_dirty: got %b required %b (txn %0d)", fill_dirty, wr, txn_id); end
      checks++; if (mem_req !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL fill_state: mem_req=%b busy=%b required 0/1 (txn %0d)", mem_req, busy, txn_id); end
      // A request raised during the fill cycle must not be taken.
      if (noise) begin drive_noise(); miss_req = 1'b1; end
      @(negedge clock);
      miss_req = 1'b0;
      checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || fill_valid !== 1'b0) begin failures++; $display("FAIL idle_after: busy=%b mem_req=%b fill_valid=%b required 0/0/0 (txn %0d)", busy, mem_req, fill_valid, txn_id); end
      $display("txn %0d addr=%b wr=%b dirty=%b wbd=%0d fd=%0d fill=%h", txn_id, a, wr, vd, wbd, fd, exp_fill);
   endtask

   task automatic test_reset();
      #1;
      checks++; if (busy !== 1'b0 || fill_valid !== 1'b0 || fill_dirty !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_ctrl: busy=%b fv=%b fd=%b req=%b we=%b required all 0", busy, fill_valid, fill_dirty, mem_req, mem_we); end
      checks++; if (fill_data !== 8'h00 || mem_addr !== 5'd0 || mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_data: fill_data=%h mem_addr=%b mem_wdata=%h required 0", fill_data, mem_addr, mem_wdata); end
`ifdef CACHE_STATS_EN
      checks++; if (miss_count !== 8'd0 || wb_count !== 8'd0) begin failures++; $display("FAIL reset_stats: miss=%0d wb=%0d required 0/0", miss_count, wb_count); end
`endif
      @(negedge clock);
      miss_req = 1'b1;
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_hold: busy=%b required 0 while in reset", busy); end
      miss_req = 1'b0;
      resetn = 1'b1;
   endtask

   task automatic test_clean_read();
      run_miss(5'b10011, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 8'hA5, 0, 1, 1'b0);
   endtask

   task automatic test_dirty_evict();
      run_miss(5'b11010, 1'b0, 8'h00, 1'b1, 2'b01, 8'h3C, 8'h5A, 0, 0, 1'b0);
   endtask

   task automatic test_write_miss();
      run_miss(5'b00101, 1'b1, 8'h7E, 1'b0, 2'b10, 8'hFF, 8'h11, 0, 2, 1'b0);
   endtask

   task automatic test_long_wait();
      run_miss(5'b01110, 1'b0, 8'h00, 1'b1, 2'b11, 8'hC3, 8'h96, 10, 3, 1'b1);
   endtask

   task automatic test_reset_mid_fetch();
      miss_req = 1'b1; req_addr = 5'b01001; req_wren = 1'b0; victim_dirty = 1'b0;
      @(negedge clock);
      miss_req = 1'b0;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL midrst_pre: mem_req=%b required 1", mem_req); end
      #2 resetn = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 5'd0) begin failures++; $display("FAIL midrst_async: mem_req=%b busy=%b mem_addr=%b required 0/0/0", mem_req, busy, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      @(negedge clock);
      checks++; if (fill_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_nofill: fill_valid=%b busy=%b required 0/0", fill_valid, busy); end
      mem_ack = 1'b0;
      resetn = 1'b1;
      run_miss(5'b10110, 1'b0, 8'h00, 1'b1, 2'b00, 8'h42, 8'h24, 1, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++)
         run_miss(5'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
   endtask

`ifdef CACHE_STATS_EN
   task automatic test_stats();
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      for (int n = 0; n < 300; n++)
         run_miss(5'($urandom), 1'b0, 8'h00, 1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0);
      checks++; if (miss_count !== 8'd255 || wb_count !== 8'd255) begin failures++; $display("FAIL stats_sat: miss=%0d wb=%0d required 255/255", miss_count, wb_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_clean_read();
      test_dirty_evict();
      test_write_miss();
      test_long_wait();
      test_reset_mid_fetch();
      test_random();
`ifdef CACHE_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
